// File: rtl/gpr_pkg.sv
// Purpose: shared constants, types and helpers for the RV64 integer register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpr_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xlen_t;

    localparam reg_idx_t REG_ZERO = '0;

    // Population count of a per-register busy vector; result fits 0..NREG.
    function automatic logic [AW:0] busy_popcount(input logic [NREG-1:0] vec);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt = cnt + {{AW{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Purpose: per-register pending-write bits (flush > issue set > write-back clear) plus their popcount.
// Latency: busy bits and pending_cnt update together one clock after issue/write-back/flush.
// Backpressure: none; decode must not issue to a register whose busy bit is set (asserted).
module gpr_scoreboard
    import gpr_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  reg_idx_t        issue_rd,
    input  logic            wb_wen,
    input  reg_idx_t        wb_rd,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [AW:0]     pending_cnt
);

    logic [NREG-1:0] busy_nxt;

    // Next busy state per register; x0 is never tracked.
    always_comb begin
        busy_nxt    = busy;
        busy_nxt[0] = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (issue_valid && (issue_rd == reg_idx_t'(r))) begin
                // the issuing instruction is younger than the one retiring
                busy_nxt[r] = 1'b1;
            end else if (wb_wen && (wb_rd == reg_idx_t'(r))) begin
                busy_nxt[r] = 1'b0;
            end
        end
    end

    // Busy vector and its count are registered in lockstep so they always agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= '0;
            pending_cnt <= '0;
        end else begin
            busy        <= busy_nxt;
            pending_cnt <= busy_popcount(busy_nxt);
        end
    end

    // Only one outstanding writer per register can be tracked by a single bit.
    a_single_writer: assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && (issue_rd != REG_ZERO) && busy[issue_rd]))
        else $error("issue to register with a pending write");

endmodule

// File: rtl/gpr_regfile.sv
// Purpose: 32x64 RV64 integer register file, one write port, two combinational read ports, RAW scoreboard.
// Latency: reads combinational; writes visible next cycle (same cycle when GPR_REGFILE_WB_BYPASS_EN is defined).
// Backpressure: none; decode stalls on busy, the file never stalls write-back.
module gpr_regfile
    import gpr_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] regfile_i_wb_rd,
    input  logic [XLEN-1:0] regfile_i_wb_data,
    input  logic          regfile_i_wb_wen,
    input  logic [AW-1:0] regfile_i_rs1,
    input  logic [AW-1:0] regfile_i_rs2,
    output logic [XLEN-1:0] regfile_o_rs1_data,
    output logic [XLEN-1:0] regfile_o_rs2_data,
    output logic          regfile_o_rs1_busy,
    output logic          regfile_o_rs2_busy,
    input  logic          regfile_i_issue_valid,
    input  logic [AW-1:0] regfile_i_issue_rd,
    input  logic          regfile_i_flush,
    output logic [AW:0]   regfile_o_pending_cnt
);

    xlen_t           regs [NREG];
    logic [NREG-1:0] busy;
    logic            wb_live;

    assign wb_live = regfile_i_wb_wen && (regfile_i_wb_rd != REG_ZERO);

    gpr_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (regfile_i_issue_valid),
        .issue_rd    (regfile_i_issue_rd),
        .wb_wen      (regfile_i_wb_wen),
        .wb_rd       (regfile_i_wb_rd),
        .flush       (regfile_i_flush),
        .busy        (busy),
        .pending_cnt (regfile_o_pending_cnt)
    );

    // Storage; x0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[regfile_i_wb_rd] <= regfile_i_wb_data;
        end
    end

    // Read muxes: x0 reads zero and idle; optional write-back forwarding.
    always_comb begin
        regfile_o_rs1_data = regs[regfile_i_rs1];
        regfile_o_rs2_data = regs[regfile_i_rs2];
        regfile_o_rs1_busy = busy[regfile_i_rs1];
        regfile_o_rs2_busy = busy[regfile_i_rs2];
`ifdef GPR_REGFILE_WB_BYPASS_EN
        if (wb_live && (regfile_i_rs1 == regfile_i_wb_rd)) begin
            regfile_o_rs1_data = regfile_i_wb_data;
            regfile_o_rs1_busy = regfile_i_issue_valid && (regfile_i_issue_rd == regfile_i_rs1);
        end
        if (wb_live && (regfile_i_rs2 == regfile_i_wb_rd)) begin
            regfile_o_rs2_data = regfile_i_wb_data;
            regfile_o_rs2_busy = regfile_i_issue_valid && (regfile_i_issue_rd == regfile_i_rs2);
        end
`endif
        if (regfile_i_rs1 == REG_ZERO) begin
            regfile_o_rs1_data = '0;
            regfile_o_rs1_busy = 1'b0;
        end
        if (regfile_i_rs2 == REG_ZERO) begin
            regfile_o_rs2_data = '0;
            regfile_o_rs2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_gpr_regfile.sv
// Purpose: self-checking bench for gpr_regfile against a behavioural model and expectation queue.
// Latency: samples outputs mid-cycle, model advances on each rising clk.
// Backpressure: n/a.
module tb_gpr_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_wen;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [5:0]  pending_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    logic [63:0] m_mem [32];
    logic [31:0] m_busy;

    gpr_regfile dut (
        .clk                   (clk),
        .rst                   (rst),
        .regfile_i_wb_rd       (wb_rd),
        .regfile_i_wb_data     (wb_data),
        .regfile_i_wb_wen      (wb_wen),
        .regfile_i_rs1         (rs1),
        .regfile_i_rs2         (rs2),
        .regfile_o_rs1_data    (rs1_data),
        .regfile_o_rs2_data    (rs2_data),
        .regfile_o_rs1_busy    (rs1_busy),
        .regfile_o_rs2_busy    (rs2_busy),
        .regfile_i_issue_valid (issue_valid),
        .regfile_i_issue_rd    (issue_rd),
        .regfile_i_flush       (flush),
        .regfile_o_pending_cnt (pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 1; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic logic [63:0] m_data(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
`ifdef GPR_REGFILE_WB_BYPASS_EN
        if (wb_wen && wb_rd == idx) return wb_data;
`endif
        return m_mem[idx];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
`ifdef GPR_REGFILE_WB_BYPASS_EN
        if (wb_wen && wb_rd == idx) return issue_valid && (issue_rd == idx);
`endif
        return m_busy[idx];
    endfunction

    task automatic push_expect(input string lbl);
        exp_q.push_back('{{lbl, ".rs1_data"}, m_data(rs1)});
        exp_q.push_back('{{lbl, ".rs2_data"}, m_data(rs2)});
        exp_q.push_back('{{lbl, ".rs1_busy"}, {63'd0, m_rbusy(rs1)}});
        exp_q.push_back('{{lbl, ".rs2_busy"}, {63'd0, m_rbusy(rs2)}});
        exp_q.push_back('{{lbl, ".cnt"}, 64'(m_cnt())});
    endtask

    task automatic compare_outputs();
        logic [63:0] obs [5];
        exp_t e;
        obs[0] = rs1_data;
        obs[1] = rs2_data;
        obs[2] = {63'd0, rs1_busy};
        obs[3] = {63'd0, rs2_busy};
        obs[4] = {58'd0, pending_cnt};
        for (int k = 0; k < 5; k++) begin
            if (exp_q.size() == 0) begin
                check("queue_underflow", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check(e.tag, obs[k], e.val);
            end
        end
    endtask

    task automatic push_and_check(input string lbl);
        push_expect(lbl);
        compare_outputs();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 64'd0;
        m_busy = 32'd0;
    endtask

    task automatic model_update();
        logic [31:0] nb;
        nb = m_busy;
        for (int r = 1; r < 32; r++) begin
            if (flush) nb[r] = 1'b0;
            else if (issue_valid && issue_rd == 5'(r)) nb[r] = 1'b1;
            else if (wb_wen && wb_rd == 5'(r)) nb[r] = 1'b0;
        end
        nb[0] = 1'b0;
        if (wb_wen && wb_rd != 5'd0) m_mem[wb_rd] = wb_data;
        m_busy = nb;
    endtask

    task automatic idle();
        wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
        issue_valid = 1'b0; issue_rd = 5'd0; flush = 1'b0;
        rs1 = 5'd0; rs2 = 5'd0;
    endtask

    // One clock: sample mid-cycle, then advance the model on the rising edge.
    task automatic tick(input string lbl);
        #3;
        push_and_check(lbl);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        model_reset();
        rs1 = 5'd5; rs2 = 5'd31;
        #3;
        push_and_check("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_update();
        #1;

        // Write x5, issue to x5, then reset in the middle of a cycle.
        idle(); wb_wen = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD; rs1 = 5'd5;
        tick("wr5");
        idle(); rs1 = 5'd5; issue_valid = 1'b1; issue_rd = 5'd5;
        tick("rd5");
        idle(); rs1 = 5'd5;
        #2;
        push_and_check("pre_rst");
        rst = 1'b1;
        model_reset();
        #1;
        push_and_check("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_update();
        #1;

        // x0 protection.
        idle(); wb_wen = 1'b1; wb_rd = 5'd0; wb_data = 64'hFFFF_FFFF_FFFF_FFFF;
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick("x0_wr");
        idle(); rs2 = 5'd0;
        tick("x0_rd");

        // Issue and retire x7.
        idle(); issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
        tick("iss7");
        idle(); wb_wen = 1'b1; wb_rd = 5'd7; wb_data = 64'h1234; rs1 = 5'd7;
        tick("wb7");
        idle(); rs1 = 5'd7;
        tick("ret7");

        // Same-cycle set and clear on x9: set wins, data still written.
        idle(); wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 64'h9999; issue_valid = 1'b1; issue_rd = 5'd9;
        rs1 = 5'd9;
        tick("setclr9");
        idle(); rs1 = 5'd9;
        tick("after9");
        idle(); wb_wen = 1'b1; wb_rd = 5'd9; wb_data = 64'h9A9A;
        tick("ret9");

        // Forwarding window on x3.
        idle(); wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 64'h1111;
        tick("wr3_old");
        idle(); wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 64'hABCD; rs2 = 5'd3; rs1 = 5'd3;
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick("byp3");
        idle(); rs2 = 5'd3;
        tick("after3");
        idle(); wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 64'hABCE;
        tick("ret3");

        // Flush beats issue; write-back in the flush cycle still lands.
        idle(); issue_valid = 1'b1; issue_rd = 5'd1;
        tick("iss1");
        idle(); issue_valid = 1'b1; issue_rd = 5'd2;
        tick("iss2");
        idle(); issue_valid = 1'b1; issue_rd = 5'd31; rs1 = 5'd1; rs2 = 5'd2;
        tick("iss31");
        idle(); flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd4;
        wb_wen = 1'b1; wb_rd = 5'd2; wb_data = 64'h2222; rs1 = 5'd31; rs2 = 5'd1;
        tick("flush");
        idle(); rs1 = 5'd4; rs2 = 5'd2;
        tick("post_flush");
        idle(); rs1 = 5'd31;
        tick("post_flush2");

        // Random traffic honouring the single-writer precondition.
        for (int n = 0; n < 300; n++) begin
            idle();
            wb_wen      = 1'($urandom_range(0, 1));
            wb_rd       = 5'($urandom_range(0, 31));
            wb_data     = {$urandom, $urandom};
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 31));
            if (issue_rd != 5'd0 && m_busy[issue_rd]) issue_valid = 1'b0;
            flush       = ($urandom_range(0, 15) == 0);
            rs1         = ($urandom_range(0, 3) == 0) ? wb_rd : 5'($urandom_range(0, 31));
            rs2         = ($urandom_range(0, 3) == 0) ? issue_rd : 5'($urandom_range(0, 31));
            tick("rand");
        end

        idle();
        #3;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_regfile.md
Name: gpr_regfile

Overview:
- 32 x 64-bit integer register file for the RV64 core.
- Consumes the write-back stage's rd / data / reg_wen triple on its write port.
- Serves two combinational read ports to decode.
- Holds a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight instructions.

Parameters:
XLEN, 64, register data width
NREG, 32, number of architectural registers (x0 hardwired zero)
AW, 5, register index width (log2 NREG)

Ports:
clk  input  1  core clock
rst  input  1  reset; asynchronous, active-high
regfile_i_wb_rd  input  AW  write-back destination index
regfile_i_wb_data  input  XLEN  write-back data
regfile_i_wb_wen  input  1  write-back enable
regfile_i_rs1  input  AW  read port 1 index
regfile_i_rs2  input  AW  read port 2 index
regfile_o_rs1_data  output  XLEN  read port 1 data
regfile_o_rs2_data  output  XLEN  read port 2 data
regfile_o_rs1_busy  output  1  rs1 has a pending write not yet retired
regfile_o_rs2_busy  output  1  rs2 has a pending write not yet retired
regfile_i_issue_valid  input  1  decode issues an instruction that writes rd
regfile_i_issue_rd  input  AW  destination of the issued instruction
regfile_i_flush  input  1  pipeline flush; clear all busy bits
regfile_o_pending_cnt  output  AW+1  number of busy registers

Behaviour:
- Reset (rst high, asynchronous):
  - all 32 registers <= 0
  - all busy bits <= 0, pending_cnt <= 0
  - read outputs then reflect zeros
  - reset asserted mid-operation discards every pending write and scoreboard entry immediately
- Write:
  - on rising clk, if wb_wen and wb_rd != 0, reg[wb_rd] <= wb_data
  - writes to x0 are ignored (no storage change, no busy change)
- Reads:
  - combinational
  - index 0 always returns 0 and busy = 0
  - otherwise return reg[rs] and busy[rs]
- Scoreboard, per register r != 0, per clock:
  - set = issue_valid && issue_rd == r
  - clr = wb_wen && wb_rd == r
  - next state: flush -> 0; else set -> 1; else clr -> 0; else hold
  - set and clr on the same register in the same cycle: set wins, because the new instruction is younger
  - flush beats set; a write-back arriving in the flush cycle still updates data
- Multiple outstanding writers to the same rd are not tracked (a single bit); decode stalls issue while busy[rd] is set. This is a documented precondition and an SVA assertion: issue_valid with busy[issue_rd]==1 fires an error.
- pending_cnt:
  - registered population count of the busy bits
  - updated in the same cycle as the busy bits
  - range 0..31; never wraps

Optional Feature:
- Macro GPR_REGFILE_WB_BYPASS_EN.
- Defined:
  - a read whose index equals wb_rd while wb_wen is high (rd != 0) returns wb_data combinationally
  - busy for that register reads 0 in that cycle, unless it is also being re-issued that cycle
- Undefined:
  - reads return the stored value; the new data is visible the cycle after the write
  - busy clears the cycle after the write
  - decode must stall one extra cycle

Decomposition:
- Shared package gpr_pkg holds:
  - XLEN, NREG, AW constants
  - reg_idx_t (AW-bit) and xlen_t (XLEN-bit) typedefs
  - REG_ZERO = 0 constant
- Natural sub-module gpr_scoreboard: busy vector, set/clr/flush priority, popcount for pending_cnt. gpr_regfile instantiates it beside the storage array and read muxes.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing x5=0xDEAD -> rs1=5 reads 0 immediately, busy 0, pending_cnt 0.
- x0 protection: wb_wen=1, rd=0, data=0xFFFF_FFFF_FFFF_FFFF -> rs1=0 reads 0; issue_rd=0 -> busy stays 0, pending_cnt 0.
- Issue/retire: issue rd=7 -> next cycle busy7=1, cnt=1; wb rd=7 data=0x1234 -> next cycle rs1=7 reads 0x1234, busy 0, cnt 0.
- Same-cycle set+clr on x9 (wb rd=9 while issue rd=9) -> busy9 stays 1, data updated to the wb value.
- Bypass: wb rd=3 data=0xABCD with rs2=3 in the same cycle -> rs2_data=0xABCD with macro defined; old value without it, new value the next cycle.
- Flush: busy on x1,x2,x31, then flush=1 plus issue rd=4 -> all busy 0 next cycle, cnt 0.
